// File: rtl/blk_pkg.sv
// Shared types and widths for the block scan controller and its counters.
package blk_pkg;

    localparam int PIX_W = 24;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        ACTIVE  = 2'd1,
        DONE    = 2'd2
    } scan_state_t;

    // Counter width that stays legal for a modulus of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blk_cnt.sv
// Mod-N counter with synchronous clear, enable, a combinational terminal tick
// and a registered wrap pulse that lines up with the registered outputs.
module blk_cnt
    import blk_pkg::*;
#(
    parameter int N = 2,
    parameter int W = cnt_w(N)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] val,
    output logic         tick,
    output logic         wrap
);

    logic [W-1:0] cnt;

    // Clear applies before the enable of the same cycle, so the current event counts as index 0.
    assign val  = clr ? '0 : cnt;
    assign tick = en & (val == W'(N - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= tick;
            if (tick)
                cnt <= '0;
            else if (en)
                cnt <= val + W'(1);
            else
                cnt <= val;
        end
    end

endmodule

// File: rtl/blk_scan.sv
// Raster scan controller and pixel mixer: derives block indices and save strobes
// for the luminance buffer and inverts pixels of blocks the buffer flags bright.
module blk_scan
    import blk_pkg::*;
#(
    parameter int HBLKS = 10,
    parameter int VBLKS = 10,
    parameter int HPXS  = 30,
    parameter int VPXS  = 30
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     vs_i,
    input  logic                     hs_i,
    input  logic                     de_i,
    input  logic [PIX_W-1:0]         data_i,
    input  logic                     en_i,
    input  logic                     rx_i,
    output logic [cnt_w(HBLKS)-1:0]  ht_o,
    output logic [cnt_w(VBLKS)-1:0]  vt_o,
    output logic                     h_save_o,
    output logic                     v_save_o,
    output logic                     de_o,
    output logic [PIX_W-1:0]         wd_o,
    output logic                     vs_o,
    output logic                     hs_o,
    output logic                     de_vo,
    output logic [PIX_W-1:0]         data_o
);

    localparam int HTW = cnt_w(HBLKS);
    localparam int VTW = cnt_w(VBLKS);
    localparam int HCW = cnt_w(HPXS);
    localparam int VCW = cnt_w(VPXS);

    function automatic logic [PIX_W-1:0] mix_pix(input logic [PIX_W-1:0] pix, input logic inv);
        return inv ? ~pix : pix;
    endfunction

    scan_state_t    state;
    logic           in_reg;
    logic           vs_p0;
    logic           hs_p0;
    logic           de_p0;

    logic           vs_rise;
    logic           de_rise;
    logic           de_fall;
    logic           act;
    logic           h_clr;
    logic           in_eff;
    logic           pix;

    logic [HCW-1:0] hcnt_val;
    logic           hcnt_tick;
    logic [HTW-1:0] ht_val;
    logic           ht_tick;
    logic           ht_wrap;
    logic [VCW-1:0] vcnt_val;
    logic           vcnt_tick;
    logic [VTW-1:0] vt_val;
    logic           vt_tick;
    logic           vt_wrap;
    logic           unused_ok;

    // The delayed syncs double as the edge-detect history.
    assign vs_rise = vs_i & ~vs_p0;
    assign de_rise = de_i & ~de_p0;
    assign de_fall = ~de_i & de_p0;

    // A vs edge resolves first, so a coincident de edge already sees the ACTIVE state.
    assign act    = vs_rise | (state == ACTIVE);
    assign h_clr  = vs_rise | de_rise;
    assign in_eff = act & (de_rise | (in_reg & ~vs_rise));
    assign pix    = de_i & in_eff;

    blk_cnt #(.N(HPXS), .W(HCW)) u_hcnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (h_clr),
        .en     (pix),
        .val    (hcnt_val),
        .tick   (hcnt_tick),
        .wrap   (h_save_o)
    );

    blk_cnt #(.N(HBLKS), .W(HTW)) u_ht (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (h_clr),
        .en     (hcnt_tick),
        .val    (ht_val),
        .tick   (ht_tick),
        .wrap   (ht_wrap)
    );

    blk_cnt #(.N(VPXS), .W(VCW)) u_vcnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (vs_rise),
        .en     (de_fall & act),
        .val    (vcnt_val),
        .tick   (vcnt_tick),
        .wrap   (v_save_o)
    );

    blk_cnt #(.N(VBLKS), .W(VTW)) u_vt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (vs_rise),
        .en     (vcnt_tick),
        .val    (vt_val),
        .tick   (vt_tick),
        .wrap   (vt_wrap)
    );

    assign unused_ok = ^{hcnt_val, vcnt_val, ht_wrap, vt_wrap};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= WAIT_VS;
            in_reg <= 1'b0;
            vs_p0  <= 1'b0;
            hs_p0  <= 1'b0;
            de_p0  <= 1'b0;
            ht_o   <= '0;
            vt_o   <= '0;
            de_o   <= 1'b0;
            wd_o   <= '0;
            vs_o   <= 1'b0;
            hs_o   <= 1'b0;
            de_vo  <= 1'b0;
            data_o <= '0;
        end else begin
            if (act)
                state <= vt_tick ? DONE : ACTIVE;
            in_reg <= in_eff & ~ht_tick;

            // p0: buffer-side outputs, one cycle after the input pixel
            vs_p0 <= vs_i;
            hs_p0 <= hs_i;
            de_p0 <= de_i;
            ht_o  <= ht_val;
            vt_o  <= vt_val;
            de_o  <= pix;
            wd_o  <= data_i;

            // p1: video outputs, mixed with the block decision for the p0 pixel
            vs_o   <= vs_p0;
            hs_o   <= hs_p0;
            de_vo  <= de_p0;
            data_o <= mix_pix(wd_o, en_i & rx_i & de_o);
        end
    end

endmodule

// File: doc/blk_scan.md
# blk_scan

Scan controller and pixel mixer on the video path ahead of, and behind, the per-block luminance buffer. It tracks raster position from incoming sync/DE and produces the block indices (`ht_o`, `vt_o`), the per-block and per-block-row save strobes, and the delayed pixel word the buffer accumulates. It also consumes the buffer's one-bit block decision (`rx_i`) and inverts the pixels of blocks flagged bright. One instance sits between the HDMI/DVI receiver and the transmitter.

## Interface
- `HBLKS`, 10: blocks per line
- `VBLKS`, 10: block rows per frame
- `HPXS`, 30: pixels per block horizontally
- `VPXS`, 30: lines per block vertically

- `clk_i` in 1: pixel clock
- `rst_ni` in 1: reset, asynchronous assert, active-low
- `vs_i`, `hs_i`, `de_i` in 1 each: input sync/enable, active-high
- `data_i` in 24: input pixel, R[23:16] G[15:8] B[7:0]
- `en_i` in 1: 1 = inversion enabled; 0 = pixel passthrough, strobes still generated
- `rx_i` in 1: block decision for the block currently on the video output; 1 = bright, invert
- `ht_o` out clog2(HBLKS): horizontal block index
- `vt_o` out clog2(VBLKS): vertical block index
- `h_save_o` out 1: one-cycle pulse on the last pixel of each block on every line
- `v_save_o` out 1: one-cycle pulse after the last line of each block row
- `de_o` out 1: in-region pixel qualifier to the buffer
- `wd_o` out 24: pixel word to the buffer
- `vs_o`, `hs_o`, `de_vo` out 1 each: delayed sync to the transmitter
- `data_o` out 24: mixed pixel

## Operation
- States:
  - WAIT_VS: after reset. Moves to ACTIVE on a `vs_i` rising edge.
  - ACTIVE: region scanning. Moves to DONE after the v_save of row VBLKS-1.
  - DONE: no strobes. Moves to ACTIVE on a `vs_i` rising edge.
- A `vs_i` rising edge in any state clears hcnt, ht, vcnt and vt.
- Horizontal counting: a `de_i` rising edge clears hcnt and ht and sets the in-region flag. Each `de_i` cycle while in region increments hcnt.
  - At hcnt==HPXS-1: `h_save_o`=1, hcnt wraps to 0, ht increments.
  - After ht==HBLKS-1 wraps, the line is out of region. Further pixels produce no strobes and `de_o`=0.
- Vertical counting: on a `de_i` falling edge in ACTIVE, vcnt increments (wrap at VPXS-1).
  - On wrap, `v_save_o` pulses one cycle and vt increments.
  - Lines shorter than HBLKS*HPXS still count as lines.
- Mixing: `data_o` = (`en_i` & `rx_i` & in-region) ? ~pixel : pixel. Inversion is bitwise on all 24 bits. Pixels outside the region, and all pixels in WAIT_VS/DONE, pass unmodified.
- Simultaneous events: a `vs_i` rising edge on the same cycle as a `de_i` edge is resolved with vs first; counters clear, then the de edge is applied.

## Timing
- Buffer-side outputs (`ht_o`, `vt_o`, `h_save_o`, `de_o`, `wd_o`) are registered, 1 cycle after the input pixel, and mutually aligned. `ht_o` and `vt_o` show the block of `wd_o`.
- `v_save_o` is asserted in the cycle after the `de_o` of the last pixel of the line, i.e. 1 cycle after the `de_i` falling edge.
- Video outputs have 2-cycle latency. `vs_o`, `hs_o` and `de_vo` are delayed identically. `rx_i` is sampled in the cycle before `data_o` updates.
- Reset values: all outputs 0; state WAIT_VS.
- Reset asserted mid-frame: outputs are 0 immediately. After release the block stays in WAIT_VS, passing video through unmodified (after the 2-cycle delay) until the next `vs_i` rising edge.

## Structure
- Package `blk_pkg`: the state enum and pixel-word width 24. HBLKS/VBLKS/HPXS/VPXS stay module parameters.
- Sub-module `blk_cnt` (params N, width clog2(N)): mod-N counter with clear, enable and a registered wrap pulse. Instantiated four times (hcnt, ht, vcnt, vt).

## Test plan
All scenarios use HBLKS=2, VBLKS=2, HPXS=3, VPXS=2.
- Reset release, then vs pulse, then one 6-pixel line -> `h_save_o` high at output cycles 3 and 6; `ht_o` sequence 0,0,0,1,1,1; `v_save_o` stays 0.
- Full frame of 4 lines × 6 pixels -> `v_save_o` pulses after lines 2 and 4; `vt_o`=1 on lines 3–4; no strobes on a 5th line (DONE).
- 8-pixel line -> pixels 7–8 have `de_o`=0, no `h_save_o`, `data_o`=`data_i` delayed.
- `en_i`=1, `rx_i`=1, `data_i`=24'h123456 in region -> `data_o`=24'hEDCBA9 two cycles later; with `en_i`=0 the output is 24'h123456.
- `rst_ni` low mid-line -> all outputs 0 at once; after release, no strobes and no inversion until `vs_i` rises.
- `vs_i` rising edge on the same cycle as a `de_i` rising edge -> counters cleared; first strobe occurs after 3 pixels.
